instr_encoder: RTL

- Program loader and instruction encoder for the multicycle ARM core, performing the inverse of the core's instruction decode.
- Accepts field-level instruction requests (condition, class, command, registers, operand) over a valid/ready handshake and assembles 32-bit ARM words.
- Writes the words sequentially into the unified instruction/data memory.
- Holds the core in reset until the program is loaded.
- Sits between the testbench/boot host and the memory write port, ahead of the core's reset input.

---
 rtl/instr_encoder_if.sv | 31 +++
 rtl/instr_encoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request and memory-write bus for instr_encoder. The host drives requests
// through the master modport; the encoder serves the slave modport.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [3:0]  req_cond;
  logic [3:0]  req_cmd;
  logic        req_imm;
  logic        req_s;
  logic        req_load;
  logic [3:0]  req_rn;
  logic [3:0]  req_rd;
  logic [23:0] req_operand;
  logic        req_last;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;

  modport master (
    output req_valid, req_kind, req_cond, req_cmd, req_imm, req_s, req_load,
           req_rn, req_rd, req_operand, req_last,
    input  req_ready, mem_we, mem_adr, mem_wd
  );

  modport slave (
    input  req_valid, req_kind, req_cond, req_cmd, req_imm, req_s, req_load,
           req_rn, req_rd, req_operand, req_last,
    output req_ready, mem_we, mem_adr, mem_wd
  );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: encodes field-level requests into ARM words and writes them
// sequentially to memory, holding the core in reset until loading completes.
// Define INSTR_ENCODER_CHECKSUM_EN to build the XOR checksum of written words.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  instr_encoder_if.slave  bus,
  output logic            cpu_reset,
  output logic            done,
  output logic            err,
  output logic [31:0]     checksum
);
  localparam int unsigned    CW  = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0]  CAP = CW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   wd_q, wd_d;

  logic          ready;
  logic          xfer;
  logic          legal;
  logic          wr;
  logic          clear;
  logic [31:0]   word;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (bus.req_kind)
      2'b00: begin
        word = {bus.req_cond, 2'b00, bus.req_imm, bus.req_cmd, bus.req_s,
                bus.req_rn, bus.req_rd, bus.req_operand[11:0]};
        case (bus.req_cmd)
          4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001: legal = 1'b1;
          default:                                     legal = 1'b0;
        endcase
      end
      2'b01: word = {bus.req_cond, 2'b01, ~bus.req_imm, 4'b1100, bus.req_load,
                     bus.req_rn, bus.req_rd, bus.req_operand[11:0]};
      2'b10: word = {bus.req_cond, 2'b10, 2'b10, bus.req_operand};
      default: legal = 1'b0;
    endcase
  end

  // pend_q marks an accepted req_last; it blocks further requests and forces
  // DONE on the next edge whether or not that request produced a write.
  assign ready = (state_q == LOAD) && (count_q < CAP) && !pend_q;
  assign xfer  = bus.req_valid && ready;
  assign wr    = xfer && legal;
  assign clear = start && (state_q != LOAD);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pend_d  = pend_q;
    err_d   = err_q;
    we_d    = 1'b0;
    adr_d   = adr_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
          pend_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (pend_q) begin
          state_d = DONE;
          pend_d  = 1'b0;
        end else if (count_q == CAP) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (xfer) begin
          if (legal) begin
            we_d    = 1'b1;
            adr_d   = BASE_ADDR + (32'(count_q) << 2);
            wd_d    = word;
            count_d = count_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (bus.req_last) pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= BASE_ADDR;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
    end
  end

`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0] chk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     chk_q <= '0;
    else if (clear) chk_q <= '0;
    else if (wr)    chk_q <= chk_q ^ word;
  end

  assign checksum = chk_q;
`else
  assign checksum = '0;
`endif

  assign bus.req_ready = ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_adr   = adr_q;
  assign bus.mem_wd    = wd_q;
  assign cpu_reset     = (state_q != DONE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
endmodule
